// File: rtl/read_controller.sv
// Frame readback: fetches NUM_PIXELS 24-bit words from the pixel BRAM and
// hands them to the UART transmitter as three bytes each, MSB first.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// READ      | en high for one cycle at the current addr
// WAIT_DATA | counting BRAM read latency, latch dout when valid
// SEND      | wait for transmitter idle, then launch the next byte
// TX_WAIT   | wait for the launched byte to finish transmitting
// FIN       | one-cycle done pulse, back to IDLE
module read_controller #(
    parameter int NUM_PIXELS = 196608,
    parameter int ADDR_W     = 18,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              en,
    output logic [ADDR_W-1:0] addr,
    input  logic [23:0]       dout,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WAIT_DATA = 3'd2,
        SEND      = 3'd3,
        TX_WAIT   = 3'd4,
        FIN       = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [1:0]        LAT_LOAD  = 2'(RD_LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  lat_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] shreg;
    logic        tx_done;

    // tx_start is registered, so it is high exactly in the first TX_WAIT
    // cycle; the transmitter has not raised busy yet, so that cycle is skipped.
    assign tx_done = (state == TX_WAIT) && !tx_start && !tx_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = READ;
            READ:      state_nxt = WAIT_DATA;
            WAIT_DATA: if (lat_cnt == 2'd0) state_nxt = SEND;
            SEND:      if (!tx_busy) state_nxt = TX_WAIT;
            TX_WAIT: begin
                if (tx_done) begin
                    if (byte_idx != 2'd2) begin
                        state_nxt = SEND;
                    end else if (addr == LAST_ADDR) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            FIN:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        en   = (state == READ);
        busy = (state == READ) || (state == WAIT_DATA) ||
               (state == SEND) || (state == TX_WAIT);
        done = (state == FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            lat_cnt  <= 2'd0;
            byte_idx <= 2'd0;
            shreg    <= 24'd0;
            tx_start <= 1'b0;
            tx_data  <= 8'd0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                READ: lat_cnt <= LAT_LOAD;
                WAIT_DATA: begin
                    if (lat_cnt == 2'd0) begin
                        shreg    <= dout;
                        byte_idx <= 2'd0;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= shreg[23:16];
                    end
                end
                TX_WAIT: begin
                    if (tx_done) begin
                        if (byte_idx != 2'd2) begin
                            shreg    <= {shreg[15:0], 8'h00};
                            byte_idx <= byte_idx + 2'd1;
                        end else if (addr == LAST_ADDR) begin
                            addr <= '0;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_read_controller.sv
// Bench for read_controller: four instances (NUM_PIXELS 2/4, RD_LATENCY 1..3)
// share one image and are checked against an arithmetic byte-stream model.
module tb_read_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hold;
    int          tx_len;

    logic        en       [4];
    logic [1:0]  addr     [4];
    logic [23:0] dout     [4];
    logic        tx_busy  [4];
    logic        tx_start [4];
    logic [7:0]  tx_data  [4];
    logic        busy     [4];
    logic        done     [4];

    logic [23:0] mem [4];

    logic [7:0]  cap [4][64];
    int          cap_n    [4];
    int          en_cnt   [4];
    int          done_cnt [4];
    logic        en_prev  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        localparam int NP  = (g == 0) ? 2 : 4;
        localparam int LAT = (g == 1) ? 1 : (g == 2) ? 3 : 2;

        logic [23:0] pipe [3];
        int          tx_cnt = 0;

        read_controller #(
            .NUM_PIXELS(NP),
            .ADDR_W    (2),
            .RD_LATENCY(LAT)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .en      (en[g]),
            .addr    (addr[g]),
            .dout    (dout[g]),
            .tx_busy (tx_busy[g]),
            .tx_start(tx_start[g]),
            .tx_data (tx_data[g]),
            .busy    (busy[g]),
            .done    (done[g])
        );

        // BRAM model: junk on dout except exactly LAT cycles after en
        always @(posedge clk) begin
            pipe[0] <= en[g] ? mem[addr[g]] : 24'hBADBAD;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign dout[g] = pipe[LAT-1];

        always @(posedge clk) begin
            if (tx_start[g]) tx_cnt <= tx_len;
            else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
        end
        assign tx_busy[g] = (tx_cnt != 0) || hold;
    end

    function automatic int np_of(int g);
        return (g == 0) ? 2 : 4;
    endfunction

    function automatic logic [7:0] exp_byte(int g, int k);
        logic [23:0] w;
        w = mem[(k / 3) % np_of(g)];
        return 8'(w >> (8 * (2 - (k % 3))));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            if (tx_start[g]) begin
                if (cap_n[g] < 64) cap[g][cap_n[g]] = tx_data[g];
                cap_n[g]++;
            end
            if (en[g]) begin
                en_cnt[g]++;
                chk($sformatf("en_width%0d", g), {31'd0, en_prev[g]}, 0);
            end
            en_prev[g] = en[g];
            if (done[g]) begin
                done_cnt[g]++;
                chk($sformatf("bytes_at_done%0d", g), cap_n[g], 3 * np_of(g));
            end
        end
    endtask

    task automatic clear_stats();
        for (int g = 0; g < 4; g++) begin
            cap_n[g]    = 0;
            en_cnt[g]   = 0;
            done_cnt[g] = 0;
        end
    endtask

    function automatic bit all_done();
        for (int g = 0; g < 4; g++) if (done_cnt[g] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs until every instance has pulsed done; optionally pokes start
    // while busy and in the FIN cycle of instance 0.
    task automatic run_to_done(input bit pokes);
        int n;
        int poke_at;
        bit poked;
        n = 0;
        poked = 1'b0;
        poke_at = $urandom_range(2, 20);
        while (!all_done() && n < 3000) begin
            tick();
            n++;
            start = 1'b0;
            if (pokes && (n == poke_at || n == 2)) start = 1'b1;
            if (pokes && done[0] && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end
        end
        start = 1'b0;
        chk("frame_completes", {31'd0, all_done()}, 1);
        for (int i = 0; i < 8; i++) tick();
        if (pokes) begin
            chk("fin_start_ignored_busy", {31'd0, busy[0]}, 0);
            chk("fin_start_ignored_en", en_cnt[0], 2);
        end
    endtask

    task automatic check_frame(string tag);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s_bytes%0d", tag, g), cap_n[g], 3 * np_of(g));
            for (int k = 0; k < cap_n[g] && k < 64; k++)
                chk($sformatf("%s_byte%0d_%0d", tag, g, k), {24'd0, cap[g][k]},
                    {24'd0, exp_byte(g, k)});
            chk($sformatf("%s_en%0d", tag, g), en_cnt[g], np_of(g));
            chk($sformatf("%s_done%0d", tag, g), done_cnt[g], 1);
            chk($sformatf("%s_addr%0d", tag, g), {30'd0, addr[g]}, 0);
            chk($sformatf("%s_busy%0d", tag, g), {31'd0, busy[g]}, 0);
        end
    endtask

    typedef struct {
        int         inst;
        int         idx;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int n;
        tbl[0]  = '{0, 0, 8'hA1};  tbl[1]  = '{0, 1, 8'hB2};
        tbl[2]  = '{0, 2, 8'hC3};  tbl[3]  = '{0, 3, 8'h0D};
        tbl[4]  = '{0, 4, 8'h0E};  tbl[5]  = '{0, 5, 8'h0F};
        tbl[6]  = '{3, 6, 8'h12};  tbl[7]  = '{3, 7, 8'h34};
        tbl[8]  = '{3, 8, 8'h56};  tbl[9]  = '{3, 9, 8'hFF};
        tbl[10] = '{2, 10, 8'hEE}; tbl[11] = '{1, 11, 8'h00};

        rst = 1'b1; start = 1'b0; hold = 1'b0; tx_len = 10;
        mem[0] = 24'hA1B2C3; mem[1] = 24'h0D0E0F;
        mem[2] = 24'h123456; mem[3] = 24'hFFEE00;
        for (int g = 0; g < 4; g++) en_prev[g] = 1'b0;
        clear_stats();
        tick(); tick();
        for (int g = 0; g < 4; g++)
            chk($sformatf("reset_outs%0d", g),
                {18'd0, en[g], addr[g], tx_start[g], tx_data[g], busy[g], done[g]}, 0);
        rst = 1'b0;
        tick();

        // Fixed image frame against the vector table
        clear_stats();
        pulse_start();
        chk("busy_after_start", {31'd0, busy[0]}, 1);
        run_to_done(1'b0);
        for (int i = 0; i < 12; i++)
            chk($sformatf("tbl%0d", i), {24'd0, cap[tbl[i].inst][tbl[i].idx]},
                {24'd0, tbl[i].exp});
        check_frame("frame1");

        // Second identical frame, with starts while busy and during FIN
        clear_stats();
        pulse_start();
        run_to_done(1'b1);
        check_frame("frame2");

        // Transmitter held busy as SEND is entered
        clear_stats();
        hold = 1'b1;
        pulse_start();
        for (int i = 0; i < 50; i++) tick();
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("hold_no_tx%0d", g), cap_n[g], 0);
            chk($sformatf("hold_busy%0d", g), {31'd0, busy[g]}, 1);
        end
        hold = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        for (int g = 0; g < 4; g++) chk($sformatf("release_one_tx%0d", g), cap_n[g], 1);
        run_to_done(1'b0);
        check_frame("hold");

        // Reset after the 4th byte of instance 0
        clear_stats();
        pulse_start();
        n = 0;
        while (cap_n[0] < 4 && n < 1000) begin
            tick();
            n++;
        end
        chk("reach_4th_byte", cap_n[0], 4);
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 4; g++)
            chk($sformatf("async_reset_outs%0d", g),
                {18'd0, en[g], addr[g], tx_start[g], tx_data[g], busy[g], done[g]}, 0);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("abort_no_more_tx", cap_n[0], 4);
        for (int g = 0; g < 4; g++) chk($sformatf("abort_no_done%0d", g), done_cnt[g], 0);
        clear_stats();
        pulse_start();
        run_to_done(1'b0);
        chk("restart_first_byte", {24'd0, cap[0][0]}, 32'hA1);
        check_frame("restart");

        // Randomized images, transmitter timing and start pokes
        for (int f = 0; f < 6; f++) begin
            for (int a = 0; a < 4; a++) mem[a] = 24'($urandom);
            tx_len = $urandom_range(1, 12);
            clear_stats();
            pulse_start();
            run_to_done(1'($urandom_range(0, 1)));
            check_frame($sformatf("rand%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
